// File: rtl/binarization_pkg.sv
// Shared constants, types and decode helpers for the thermometer-to-pixel output decoder.
package binarization_pkg;

    localparam int PARAM_IN_CNT = 784;
    localparam int PARAM_IN_BIT = 2;
    localparam int PARAM_CH_CNT = 2 ** PARAM_IN_BIT;
    localparam int PARAM_LANES  = 16;
    localparam int BEATS        = PARAM_IN_CNT / PARAM_LANES;
    localparam int ONES_W       = $clog2(PARAM_CH_CNT + 1);
    localparam int CNT_W        = $clog2(BEATS);

    typedef logic [PARAM_CH_CNT-1:0]        thermo_t;
    typedef logic signed [PARAM_IN_BIT-1:0] pix_t;
    typedef logic [ONES_W-1:0]              ones_t;
    typedef logic [PARAM_IN_BIT:0]          wide_t;
    typedef logic [CNT_W-1:0]               cnt_t;

    function automatic ones_t popcount(input thermo_t code);
        ones_t n;
        n = '0;
        for (int i = 0; i < PARAM_CH_CNT; i++) begin
            n = n + ones_t'(code[i]);
        end
        return n;
    endfunction

    // Legal codes are ones packed from bit 0 with at least one zero left over.
    function automatic bit is_thermo(input thermo_t code);
        bit seen_zero;
        bit ok;
        seen_zero = 1'b0;
        ok        = 1'b1;
        for (int i = 0; i < PARAM_CH_CNT; i++) begin
            if (code[i]) begin
                if (seen_zero) begin
                    ok = 1'b0;
                end else begin
                    ok = ok;
                end
            end else begin
                seen_zero = 1'b1;
            end
        end
        return ok && seen_zero;
    endfunction

    function automatic pix_t ones_to_pix(input ones_t ones);
        wide_t w;
        if (ones == ones_t'(PARAM_CH_CNT)) begin
            w = wide_t'(PARAM_CH_CNT / 2 - 1);
        end else begin
            w = wide_t'(ones) - wide_t'(PARAM_CH_CNT / 2);
        end
        return pix_t'(w);
    endfunction

endpackage

// File: rtl/binarization_output_decoder_lane.sv
// One-lane combinational thermometer decode: popcount plus legality flag.
module thermo_lane_decode
    import binarization_pkg::*;
(
    input  thermo_t code,
    output ones_t   ones,
    output logic    legal
);

    assign ones  = popcount(code);
    assign legal = is_thermo(code);

endmodule

// File: rtl/binarization_output_decoder.sv
// Two-stage valid/ready pipeline decoding thermometer-coded lanes into signed pixels,
// with per-frame beat counting and a sticky frame-error flag.
module binarization_output_decoder
    import binarization_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [PARAM_LANES-1:0][PARAM_CH_CNT-1:0]  in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [PARAM_LANES-1:0][PARAM_IN_BIT-1:0]  out_data,
    output logic [PARAM_LANES-1:0]                    out_err,
    output logic                                      out_last,
    output logic                                      frame_err
);

    logic [PARAM_LANES-1:0][ONES_W-1:0]       lane_ones_s;
    logic [PARAM_LANES-1:0]                   lane_legal_s;
    logic [PARAM_LANES-1:0][ONES_W-1:0]       ones_r;
    logic [PARAM_LANES-1:0]                   legal_r;
    logic                                     last1_r;
    logic                                     v1_r;
    logic [PARAM_LANES-1:0][PARAM_IN_BIT-1:0] out_data_r;
    logic [PARAM_LANES-1:0]                   out_err_r;
    logic                                     out_last_r;
    logic                                     frame_err_r;
    logic                                     v2_r;
    logic                                     sticky_r;
    cnt_t                                     cnt_r;
    logic [PARAM_LANES-1:0][PARAM_IN_BIT-1:0] pix_nxt_s;
    logic [PARAM_LANES-1:0]                   err_nxt_s;
    logic                                     sticky_nxt_s;
    logic                                     load1_s;
    logic                                     load2_s;
    logic                                     in_fire_s;
    logic                                     out_fire_s;

    for (genvar g = 0; g < PARAM_LANES; g++) begin : g_lane
        thermo_lane_decode u_dec (
            .code  (in_data[g]),
            .ones  (lane_ones_s[g]),
            .legal (lane_legal_s[g])
        );
    end

    // A stage loads when it is empty or its successor is draining.
    assign load2_s    = !v2_r || out_ready;
    assign load1_s    = !v1_r || load2_s;
    assign in_fire_s  = in_valid && load1_s;
    assign out_fire_s = v2_r && out_ready;

    assign in_ready  = load1_s;
    assign out_valid = v2_r;
    assign out_data  = out_data_r;
    assign out_err   = out_err_r;
    assign out_last  = out_last_r;
    assign frame_err = frame_err_r;

    // Beat position within the frame, wrapping at the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (in_fire_s) begin
            cnt_r <= (cnt_r == cnt_t'(BEATS - 1)) ? '0 : cnt_r + cnt_t'(1);
        end
    end

    // Stage 1: popcount, contiguity and last tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r    <= 1'b0;
            ones_r  <= '0;
            legal_r <= '0;
            last1_r <= 1'b0;
        end else if (load1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                ones_r  <= lane_ones_s;
                legal_r <= lane_legal_s;
                last1_r <= (cnt_r == cnt_t'(BEATS - 1));
            end
        end
    end

    // Stage 2 next values; the sticky clear on the last handshake wins over any set.
    always_comb begin
        sticky_nxt_s = sticky_r;
        pix_nxt_s    = '0;
        err_nxt_s    = ~legal_r;
        if (out_fire_s && out_last_r) begin
            sticky_nxt_s = 1'b0;
        end else if (out_fire_s) begin
            sticky_nxt_s = sticky_r | (|out_err_r);
        end else begin
            sticky_nxt_s = sticky_r;
        end
        for (int l = 0; l < PARAM_LANES; l++) begin
            pix_nxt_s[l] = ones_to_pix(ones_r[l]);
        end
    end

    // Stage 2: decoded value, error flags, last and frame error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_r        <= 1'b0;
            out_data_r  <= '0;
            out_err_r   <= '0;
            out_last_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else if (load2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                out_data_r  <= pix_nxt_s;
                out_err_r   <= err_nxt_s;
                out_last_r  <= last1_r;
                frame_err_r <= sticky_nxt_s | (|err_nxt_s);
            end
        end
    end

    // Sticky OR of lane errors over the frame's already-delivered beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= sticky_nxt_s;
        end
    end

endmodule
